pyfive_wb_master: RTL and testbench
===================================

# pyfive_wb_master

Wishbone classic initiator that turns single read/write requests from pyfive logic into bus cycles on a `wbm_*` port. It is the counterpart of the `wbs_*` responder interface on the user-project wrapper: requests arrive on a valid/ready command port, and results return on a valid/ready response port. Only one transaction is outstanding at a time. An optional watchdog terminates stalled cycles with an error.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 255: number of cycles in BUS without `ack`/`err` before the watchdog fires. Legal range 1..65535.

Ports:

- `wb_clk_i` input 1: the single clock.
- `wb_rst_ni` input 1: reset, synchronous and active-low.
- `req_valid_i` input 1: request present.
- `req_ready_o` output 1: request accepted when high together with `req_valid_i`.
- `req_we_i` input 1: 1 = write, 0 = read.
- `req_adr_i` input 32: byte address.
- `req_dat_i` input 32: write data.
- `req_sel_i` input 4: byte lane selects.
- `rsp_valid_o` output 1: response present.
- `rsp_ready_i` input 1: response consumed.
- `rsp_dat_o` output 32: read data; 0 for writes and errors.
- `rsp_err_o` output 1: bus error or timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` output 1 each: Wishbone master controls.
- `wbm_sel_o` output 4: byte lane selects.
- `wbm_adr_o` output 32: address.
- `wbm_dat_o` output 32: write data.
- `wbm_ack_i`, `wbm_err_i` input 1 each: slave termination.
- `wbm_dat_i` input 32: read data.
- `busy_o` output 1: state is not IDLE.

## Operation

- FSM states: IDLE, BUS, RSP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, register we/adr/dat/sel and go to BUS.
- BUS:
  - `wbm_cyc_o`=`wbm_stb_o`=1; the registered fields drive `wbm_*`.
  - On `wbm_err_i`, capture err=1 and data=0, then go to RSP.
  - Otherwise, on `wbm_ack_i`, capture err=0. Capture data=`wbm_dat_i` for reads and 0 for writes. Go to RSP.
  - `err` and `ack` in the same cycle: `err` wins.
- RSP:
  - `rsp_valid_o`=1; `rsp_dat_o` and `rsp_err_o` hold steady until `rsp_valid_o && rsp_ready_i`, then go to IDLE.
- `req_ready_o` is 0 in BUS and RSP. A new request is never accepted in the cycle a response is consumed.
- `wbm_ack_i`/`wbm_err_i` outside BUS are ignored.
- All outputs are registered. `wbm_*` outputs are 0 whenever not in BUS.
- Reset values: all outputs 0 except `req_ready_o`=1. State is IDLE and the timeout counter is 0.
- Reset mid-transaction: `cyc`/`stb` drop on the reset edge, and any pending response is discarded (never presented).

## Timing

- Request accepted at edge T → `wbm_cyc_o`/`wbm_stb_o` high from T+1.
- Slave `ack` sampled at edge N → `cyc`/`stb` low and `rsp_valid_o` high from N+1.
- Minimum request-to-response latency: 2 cycles (`ack` in the first BUS cycle).
- Minimum issue interval: 3 cycles per transaction.
- Response stall: BUS is already closed, so `rsp_ready_i` low holds only RSP and never the bus.

## Configuration

- Macro `PYFIVE_WB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without `ack`/`err`.
  - When the counter equals `TIMEOUT_CYCLES-1` with no termination, the FSM goes to RSP with `rsp_err_o`=1 and `rsp_dat_o`=0.
  - `cyc`/`stb` therefore stay high for exactly `TIMEOUT_CYCLES` cycles.
  - A termination (`ack`/`err`) arriving on the expiry cycle takes priority over the timeout.
- Undefined: no counter exists; BUS waits indefinitely and `rsp_err_o` reflects only `wbm_err_i`.

## Structure

- Package `pyfive_wb_pkg` holds:
  - the FSM state enum (IDLE/BUS/RSP);
  - `PYFIVE_WB_AW`=32, `PYFIVE_WB_DW`=32, `PYFIVE_WB_SELW`=4;
  - `PYFIVE_WB_TO_W`=16.
- Sub-module `pyfive_wb_timeout` (counter plus expiry compare) is instantiated only under `PYFIVE_WB_TIMEOUT_EN`.
- Everything else lives in one module.

## Test plan

- Read, slave acks on the first BUS cycle with `dat_i`=0x12345678, adr 0x3000_0010 → `wbm_adr_o`=0x3000_0010 and `we`=0. Response arrives 2 cycles after accept with `rsp_dat_o`=0x12345678 and `rsp_err_o`=0.
- Write 0xCAFEF00D, sel 4'b0011, slave acks after 5 wait cycles → `cyc`/`stb` high for 6 cycles with `wbm_dat_o`/`sel` stable; `rsp_dat_o`=0 and `err`=0.
- `ack` and `err` asserted in the same cycle on a read → `rsp_err_o`=1 and `rsp_dat_o`=0. A later stray `ack` in IDLE produces no response.
- `rsp_ready_i` held low for 10 cycles → `rsp_valid_o` and data stay stable, `req_ready_o` stays 0 and `cyc` stays 0. After consumption, `req_ready_o`=1 on the next cycle.
- With `PYFIVE_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the slave never responds → `cyc` high exactly 8 cycles, then `rsp_err_o`=1. A repeat run with `ack` on the 8th cycle returns a normal response.
- Reset asserted in the 3rd BUS cycle → `cyc`/`stb`=0 and `req_ready_o`=1 after the edge, and `rsp_valid_o` never rises.

Source files
------------

// File: rtl/pyfive_wb_pkg.sv
// Shared types and widths for the pyfive Wishbone classic initiator.
package pyfive_wb_pkg;

  localparam int unsigned PYFIVE_WB_AW   = 32;
  localparam int unsigned PYFIVE_WB_DW   = 32;
  localparam int unsigned PYFIVE_WB_SELW = 4;
  localparam int unsigned PYFIVE_WB_TO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/pyfive_wb_timeout.sv
// Bus-cycle watchdog: counts unterminated BUS cycles and flags the last allowed one.
module pyfive_wb_timeout
  import pyfive_wb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_c
);

  logic [PYFIVE_WB_TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + PYFIVE_WB_TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == PYFIVE_WB_TO_W'(LIMIT - 1));

endmodule

// File: rtl/pyfive_wb_master.sv
// Wishbone classic initiator: one request in, one bus cycle, one response out.
// Optional watchdog enabled by defining PYFIVE_WB_TIMEOUT_EN.
module pyfive_wb_master
  import pyfive_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [PYFIVE_WB_AW-1:0]   req_adr_i,
  input  logic [PYFIVE_WB_DW-1:0]   req_dat_i,
  input  logic [PYFIVE_WB_SELW-1:0] req_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [PYFIVE_WB_DW-1:0]   rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [PYFIVE_WB_SELW-1:0] wbm_sel_o,
  output logic [PYFIVE_WB_AW-1:0]   wbm_adr_o,
  output logic [PYFIVE_WB_DW-1:0]   wbm_dat_o,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i,
  input  logic [PYFIVE_WB_DW-1:0]   wbm_dat_i,
  output logic                      busy_o
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("pyfive_wb_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  wb_state_e                 state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [PYFIVE_WB_DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      cyc_q, cyc_d;
  logic                      we_q, we_d;
  logic [PYFIVE_WB_SELW-1:0] sel_q, sel_d;
  logic [PYFIVE_WB_AW-1:0]   adr_q, adr_d;
  logic [PYFIVE_WB_DW-1:0]   dat_q, dat_d;
  logic                      busy_q, busy_d;
  logic                      timeout_c;

`ifdef PYFIVE_WB_TIMEOUT_EN
  pyfive_wb_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .clr_i    ((state_q == IDLE) && req_valid_i),
    .inc_i    ((state_q == BUS) && !wbm_ack_i && !wbm_err_i),
    .expired_c(timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next state plus capture of request fields and response payload.
  always_comb begin
    state_d   = state_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = BUS;
          we_d    = req_we_i;
          sel_d   = req_sel_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
        end
      end
      BUS: begin
        if (wbm_err_i) begin
          state_d   = RSP;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
        end else if (wbm_ack_i) begin
          state_d   = RSP;
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
        end else if (timeout_c) begin
          state_d   = RSP;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
          rsp_dat_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs reflect the upcoming state; bus fields are zero outside BUS.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    cyc_d       = (state_d == BUS);
    busy_d      = (state_d != IDLE);
    if (state_d != BUS) begin
      we_d  = 1'b0;
      sel_d = '0;
      adr_d = '0;
      dat_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pyfive_wb_master.sv
// Scoreboard bench for pyfive_wb_master; watchdog cases run when PYFIVE_WB_TIMEOUT_EN is defined.
module tb_pyfive_wb_master;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack = 1'b0;
  logic        wbm_err = 1'b0;
  logic [31:0] wbm_dat = '0;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pyfive_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we),
    .req_adr_i  (req_adr),
    .req_dat_i  (req_dat),
    .req_sel_i  (req_sel),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack),
    .wbm_err_i  (wbm_err),
    .wbm_dat_i  (wbm_dat),
    .busy_o     (busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every consumed response is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got dat 0x%08h err %0b with nothing expected at %0t",
                   rsp_dat_o, rsp_err_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_dat", rsp_dat_o, e.dat);
          chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
        end
      end
    end
  end

  // mode: 0 ack, 1 err, 2 ack+err, 3 no termination
  task automatic do_txn(input string nm, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] sdat,
                        input int term_at, input int mode, input int exp_cyc,
                        input logic [31:0] exp_dat, input logic exp_err);
    int n;
    exp_q.push_back({exp_err, exp_dat});
    chk({nm, "_req_ready"}, 32'(req_ready_o), 32'd1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    n = 0;
    while (wbm_cyc_o && n < 300) begin
      chk({nm, "_stb_we_sel"}, {26'd0, wbm_stb_o, wbm_we_o, wbm_sel_o}, {26'd0, 1'b1, we, sel});
      chk({nm, "_adr"}, wbm_adr_o, adr);
      chk({nm, "_wdat"}, wbm_dat_o, dat);
      chk({nm, "_req_ready_bus"}, 32'(req_ready_o), 32'd0);
      wbm_dat = sdat;
      wbm_ack = (mode == 0 || mode == 2) && n == term_at;
      wbm_err = (mode == 1 || mode == 2) && n == term_at;
      @(posedge clk); #1;
      wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat = '0;
      n++;
    end
    chk({nm, "_cyc_cycles"}, 32'(n), 32'(exp_cyc));
    chk({nm, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    chk({nm, "_stb_low"}, 32'(wbm_stb_o), 32'd0);
    if (rsp_ready) begin
      @(posedge clk); #1;
      chk({nm, "_req_ready_after"}, 32'(req_ready_o), 32'd1);
      chk({nm, "_rsp_valid_after"}, 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_ctrl", {28'd0, rsp_valid_o, rsp_err_o, wbm_cyc_o, busy_o}, 32'd0);
    chk("rst_bus", wbm_adr_o | wbm_dat_o | 32'(wbm_sel_o) | 32'(wbm_we_o) | rsp_dat_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn("rd", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 1'b0);
    do_txn("wr", 1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'b0011, 32'hFFFF_FFFF, 5, 0, 6, 32'h0, 1'b0);
    do_txn("ackerr", 1'b0, 32'h3000_0030, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 2, 2, 32'h0, 1'b1);

    // Stray terminations in IDLE must not produce a response
    wbm_ack = 1'b1; wbm_err = 1'b1; wbm_dat = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stray_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("stray_busy", 32'(busy_o), 32'd0);
    end
    wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat = '0;

    do_txn("werr", 1'b1, 32'h3000_0040, 32'h0000_0001, 4'b1000, 32'h0, 2, 1, 3, 32'h0, 1'b1);

    // Response stall keeps RSP but never reopens the bus
    rsp_ready = 1'b0;
    do_txn("stall", 1'b0, 32'h3000_0050, 32'h0, 4'hF, 32'hA5A5_5A5A, 1, 0, 2, 32'hA5A5_5A5A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(rsp_valid_o), 32'd1);
      chk("stall_dat", rsp_dat_o, 32'hA5A5_5A5A);
      chk("stall_err", 32'(rsp_err_o), 32'd0);
      chk("stall_req_ready", 32'(req_ready_o), 32'd0);
      chk("stall_cyc", 32'(wbm_cyc_o), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_req_ready_after", 32'(req_ready_o), 32'd1);
    chk("stall_valid_after", 32'(rsp_valid_o), 32'd0);

`ifdef PYFIVE_WB_TIMEOUT_EN
    do_txn("to_expire", 1'b0, 32'h3000_0060, 32'h0, 4'hF, 32'h1111_2222, 0, 3, TO, 32'h0, 1'b1);
    do_txn("to_ack_last", 1'b0, 32'h3000_0070, 32'h0, 4'hF, 32'h89AB_CDEF, TO - 1, 0, TO,
           32'h89AB_CDEF, 1'b0);
`endif

    // Reset in the third BUS cycle discards the transaction
    req_valid = 1'b1; req_adr = 32'h3000_0080; req_sel = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0; req_adr = '0; req_sel = '0;
    chk("mrst_cyc_open", 32'(wbm_cyc_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_cyc_third", 32'(wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("mrst_req_ready", 32'(req_ready_o), 32'd1);
    chk("mrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_rsp", 32'(rsp_valid_o), 32'd0);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
